// File: rtl/ahb_rr_arbiter_if.sv
// Arbitration bus bundle between the AHB requesters and the round-robin
// arbiter. Requesters drive requests/locks/HREADY; the arbiter drives the
// grant, the address-phase owner and the data-phase owner.
interface ahb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int MW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MW-1:0]          HMASTER;
  logic                   HMASTLOCK;
  logic [MW-1:0]          HMASTER_D;
  logic                   HDVALID;

  // Requester side: raises requests, observes grants.
  modport master (
    output HBUSREQ, HLOCK, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK, HMASTER_D, HDVALID
  );

  // Arbiter side: samples requests, drives grants and owner indices.
  modport slave (
    input  HBUSREQ, HLOCK, HREADY,
    output HGRANT, HMASTER, HMASTLOCK, HMASTER_D, HDVALID
  );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// Registered round-robin AHB bus arbiter with locked transfers and a
// per-owner hold limit. All outputs are registered; a sampled request is
// granted one cycle later. Nothing advances while HREADY is low.
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD    = 4
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  ahb_rr_arbiter_if.slave    bus
);
  localparam int MW = $clog2(NUM_MASTERS);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [MW-1:0]          r_master;
  logic                   r_mastlock;
  logic [MW-1:0]          r_master_d;
  logic                   r_dvalid;
  logic [MW-1:0]          r_ptr;
  logic [HW-1:0]          r_hold;

  logic [NUM_MASTERS-1:0] w_cand;
  logic                   w_found;
  logic [MW-1:0]          w_winner;
  logic                   w_own_req;
  logic                   w_own_lock;
  int                     w_idx;

  // The current owner never competes against itself; r_grant is zero in IDLE,
  // so in IDLE every requester is a candidate.
  assign w_cand     = bus.HBUSREQ & ~r_grant;
  assign w_own_req  = |(bus.HBUSREQ & r_grant);
  assign w_own_lock = |(bus.HBUSREQ & bus.HLOCK & r_grant);

  // Round-robin search: first candidate at or after r_ptr+1, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and infers a latch.
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_idx = int'(r_ptr) + 1 + i;
      if (w_idx >= NUM_MASTERS) w_idx = w_idx - NUM_MASTERS;
      if (!w_found && w_cand[w_idx]) begin
        w_found  = 1'b1;
        w_winner = MW'(w_idx);
      end
    end
  end

  // Arbitration FSM with registered grant, owner, lock and data-phase outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!HRESETn) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_master   <= '0;
      r_mastlock <= 1'b0;
      r_master_d <= '0;
      r_dvalid   <= 1'b0;
      r_ptr      <= MW'(NUM_MASTERS - 1);
      r_hold     <= '0;
    end else if (bus.HREADY) begin
      r_master_d <= r_master;
      r_dvalid   <= (r_state == ST_OWN);
      if ((r_state == ST_IDLE || !w_own_req ||
           (!w_own_lock && r_hold == HOLD_LAST)) && w_found) begin
        // New grant: from idle, after a release, or at the hold limit.
        r_state    <= ST_OWN;
        r_grant    <= NUM_MASTERS'(1) << w_winner;
        r_master   <= w_winner;
        r_ptr      <= w_winner;
        r_hold     <= '0;
        r_mastlock <= bus.HLOCK[w_winner] & bus.HBUSREQ[w_winner];
      end else if (r_state == ST_IDLE || !w_own_req) begin
        // Nobody is asking: park the bus with no owner.
        r_state    <= ST_IDLE;
        r_grant    <= '0;
        r_master   <= '0;
        r_hold     <= '0;
        r_mastlock <= 1'b0;
      end else if (w_own_lock) begin
        // Locked owner keeps the bus; the hold limit does not apply.
        r_mastlock <= 1'b1;
      end else begin
        // Unlocked owner keeps the bus; count toward the limit, saturating.
        r_mastlock <= 1'b0;
        if (r_hold != HOLD_LAST) r_hold <= r_hold + 1'b1;
      end
    end
  end

  assign bus.HGRANT    = r_grant;
  assign bus.HMASTER   = r_master;
  assign bus.HMASTLOCK = r_mastlock;
  assign bus.HMASTER_D = r_master_d;
  assign bus.HDVALID   = r_dvalid;
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed plus randomized bench for ahb_rr_arbiter (4 masters, MAX_HOLD=4).
// A behavioural model predicts the outputs of every cycle into a queue that
// is drained after each clock edge; key scenarios also get constant checks.
module tb_ahb_rr_arbiter;
  localparam int NM       = 4;
  localparam int MAX_HOLD = 4;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] master;
    logic       mastlock;
    logic [1:0] master_d;
    logic       dvalid;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  // Reference model state (m_own = -1 means no owner).
  int   m_own, m_ptr, m_hold, m_md;
  bit   m_lock, m_dv;

  ahb_rr_arbiter_if #(.NUM_MASTERS(NM)) bus ();

  ahb_rr_arbiter #(.NUM_MASTERS(NM), .MAX_HOLD(MAX_HOLD)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] mask);
    for (int k = 1; k <= NM; k++) begin
      int c;
      c = (m_ptr + k) % NM;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.grant    = (m_own < 0) ? 4'b0000 : (4'b0001 << m_own);
    e.master   = (m_own < 0) ? 2'd0 : 2'(m_own);
    e.mastlock = m_lock;
    e.master_d = 2'(m_md);
    e.dvalid   = m_dv;
    return e;
  endfunction

  task automatic model_reset();
    m_own = -1; m_ptr = NM - 1; m_hold = 0; m_lock = 0; m_md = 0; m_dv = 0;
  endtask

  task automatic model_take(input int w, input logic [3:0] lock);
    m_own = w; m_ptr = w; m_hold = 0; m_lock = lock[w];
  endtask

  task automatic model_step(input logic [3:0] req, input logic [3:0] lock, input logic ready);
    int  nmd, w;
    bit  ndv;
    logic [3:0] others;
    if (!ready) return;
    nmd = (m_own < 0) ? 0 : m_own;
    ndv = (m_own >= 0);
    if (m_own < 0) begin
      w = rr_pick(req);
      if (w >= 0) model_take(w, lock);
    end else if (!req[m_own]) begin
      w = rr_pick(req);
      if (w >= 0) model_take(w, lock);
      else begin m_own = -1; m_hold = 0; m_lock = 0; end
    end else if (lock[m_own]) begin
      m_lock = 1;
    end else begin
      m_lock = 0;
      others = req & ~(4'b0001 << m_own);
      if (others != 4'b0000) begin
        if (m_hold == MAX_HOLD - 1) model_take(rr_pick(others), lock);
        else m_hold++;
      end else if (m_hold < MAX_HOLD - 1) begin
        m_hold++;
      end
    end
    m_md = nmd;
    m_dv = ndv;
  endtask

  // One bus cycle: drive inputs, predict, clock, then compare prediction.
  task automatic step(input logic [3:0] req, input logic [3:0] lock, input logic ready);
    exp_t obs, exp;
    bus.HBUSREQ = req;
    bus.HLOCK   = lock;
    bus.HREADY  = ready;
    model_step(req, lock, ready);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    obs = {bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, bus.HMASTER_D, bus.HDVALID};
    exp = sb_q.pop_front();
    check("scoreboard", 32'(obs), 32'(exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},    32'(bus.HGRANT),    32'h0);
    check({tag, "_master"},   32'(bus.HMASTER),   32'h0);
    check({tag, "_mastlock"}, 32'(bus.HMASTLOCK), 32'h0);
    check({tag, "_master_d"}, 32'(bus.HMASTER_D), 32'h0);
    check({tag, "_dvalid"},   32'(bus.HDVALID),   32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.HBUSREQ = '0;
    bus.HLOCK   = '0;
    bus.HREADY  = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #2 rst_n = 1'b1;

    // First grant and data-phase follow-up.
    step(4'b0110, 4'b0000, 1'b1);
    check("first_grant",  32'(bus.HGRANT),  32'b0010);
    check("first_master", 32'(bus.HMASTER), 32'd1);
    check("first_dvalid_pre", 32'(bus.HDVALID), 32'd0);
    step(4'b0110, 4'b0000, 1'b1);
    check("first_master_d", 32'(bus.HMASTER_D), 32'd1);
    check("first_dvalid",   32'(bus.HDVALID),   32'd1);
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);

    // Hold limit: 0 and 1 alternate every MAX_HOLD cycles.
    for (int i = 0; i < 12; i++) begin
      step(4'b0011, 4'b0000, 1'b1);
      check("hold_alternate", 32'(bus.HGRANT), ((i / 4) % 2 == 0) ? 32'b0001 : 32'b0010);
    end
    step(4'b0000, 4'b0000, 1'b1);

    // Locked sequence by master 2, then limit-driven handover to master 3.
    step(4'b0100, 4'b0100, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, 4'b0100, 1'b1);
      check("lock_grant",    32'(bus.HGRANT),    32'b0100);
      check("lock_mastlock", 32'(bus.HMASTLOCK), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 4'b0000, 1'b1);
      check("unlock_handover", 32'(bus.HGRANT), (i < 3) ? 32'b0100 : 32'b1000);
    end

    // HREADY stall while the owner drops its request.
    step(4'b1111, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b0111, 4'b0000, 1'b0);
      check("stall_grant",    32'(bus.HGRANT),    32'b1000);
      check("stall_master",   32'(bus.HMASTER),   32'd3);
      check("stall_master_d", 32'(bus.HMASTER_D), 32'd3);
    end
    step(4'b0111, 4'b0000, 1'b1);
    check("stall_release", 32'(bus.HGRANT), 32'b0001);

    // Back-to-back handover on release, then full release to idle.
    step(4'b0010, 4'b0000, 1'b1);
    check("b2b_owner1", 32'(bus.HGRANT), 32'b0010);
    step(4'b1001, 4'b0000, 1'b1);
    check("b2b_grant",  32'(bus.HGRANT),  32'b1000);
    check("b2b_dvalid", 32'(bus.HDVALID), 32'd1);
    step(4'b0000, 4'b0000, 1'b1);
    check("idle_grant", 32'(bus.HGRANT), 32'b0000);
    step(4'b0000, 4'b0000, 1'b1);
    check("idle_dvalid", 32'(bus.HDVALID), 32'd0);

    // Asynchronous reset in the middle of a locked ownership.
    step(4'b0100, 4'b0100, 1'b1);
    check("pre_reset_mastlock", 32'(bus.HMASTLOCK), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(4'b1111, 4'b0000, 1'b1);
    check("post_reset_grant", 32'(bus.HGRANT), 32'b0001);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] r_req, r_lock;
      r_req  = 4'($urandom_range(0, 15));
      r_lock = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      step(r_req, r_lock, ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
